decode_issue_ctrl: RTL and testbench

- Sequences instructions from the frontend through the instruction decoder into the issue stage.
- Owns the decoder input register, so the decoder sees one stable instruction at a time.
- Buffers decoded scoreboard entries in a DEPTH-entry FIFO toward issue.
- Serializes CSR/fence/WFI/exception-carrying instructions: no further fetch acceptance until commit confirms completion. Handles pipeline flush.

---
 rtl/decode_issue_ctrl_pkg.sv | 19 +
 rtl/decode_issue_ctrl_if.sv | 44 ++++
 rtl/decode_issue_ctrl_entry_fifo.sv | 65 ++++++
 rtl/decode_issue_ctrl.sv | 98 +++++++++
 tb/tb_decode_issue_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue control slice.
//   decode_ctrl_state_e : sequencing state (RUN accepts fetch, SERIAL waits on commit)
//   INSTR_W             : instruction word width presented to the decoder
//   ptr_w()             : pointer width for a circular buffer of a given depth
package decode_issue_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SERIAL = 1'b1
  } decode_ctrl_state_e;

  localparam int unsigned INSTR_W = 32;

  // A depth-1 buffer still needs a one-bit pointer to keep the vectors legal.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Handshake/bus bundle between frontend, decoder, issue and commit and the
// decode_issue_ctrl block.
//   slave  : the control block's view (fetch/decoder/issue/commit inputs in,
//            fetch_ready, decoder input register, FIFO head and stall out)
//   master : the surrounding pipeline's view (directions reversed)
interface decode_issue_ctrl_if
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned ENTRY_W = 256,
  parameter int unsigned VLEN    = 64
);
  logic               flush_i;
  logic               fetch_valid_i;
  logic               fetch_ready_o;
  logic [INSTR_W-1:0] fetch_instr_i;
  logic [VLEN-1:0]    fetch_pc_i;
  logic               fetch_is_compressed_i;
  logic               dec_valid_o;
  logic [INSTR_W-1:0] dec_instr_o;
  logic [VLEN-1:0]    dec_pc_o;
  logic               dec_is_compressed_o;
  logic [ENTRY_W-1:0] dec_entry_i;
  logic               dec_serial_i;
  logic               issue_valid_o;
  logic               issue_ready_i;
  logic [ENTRY_W-1:0] issue_entry_o;
  logic               issue_serial_o;
  logic               commit_serial_i;
  logic               stall_o;

  modport slave (
    input  flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_is_compressed_i,
    input  dec_entry_i, dec_serial_i, issue_ready_i, commit_serial_i,
    output fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_is_compressed_o,
    output issue_valid_o, issue_entry_o, issue_serial_o, stall_o
  );

  modport master (
    output flush_i, fetch_valid_i, fetch_instr_i, fetch_pc_i, fetch_is_compressed_i,
    output dec_entry_i, dec_serial_i, issue_ready_i, commit_serial_i,
    input  fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o, dec_is_compressed_o,
    input  issue_valid_o, issue_entry_o, issue_serial_o, stall_o
  );
endinterface

// File: rtl/decode_issue_ctrl_entry_fifo.sv
// decode_entry_fifo: DEPTH x WIDTH circular buffer of decoded entries.
//   clk_i/rst_i : clock, synchronous active-high reset (clears storage too)
//   clr_i       : flush, empties the buffer next cycle
//   push_i      : write wdata_i at the tail
//   pop_i       : drop the head
//   rdata_o     : head entry (holds its last value while empty)
//   count_o     : number of stored entries
// Push and pop in the same cycle while full is accepted; count is unchanged.
module decode_entry_fifo
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_i && !empty;
  // A full buffer can still take a write when the head leaves in the same cycle.
  assign do_push = push_i && !clr_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head output reads zero out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  assign rdata_o = mem[rd_ptr];
  assign count_o = count;
endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: frontend -> decoder input register -> decoded-entry FIFO
// -> issue. Serializing instructions block fetch until commit confirms them.
//   clk_i/rst_i : clock, synchronous active-high reset
//   io (slave)  : fetch handshake, decoder in/out, issue handshake,
//                 commit_serial pulse, flush, stall indication
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ENTRY_W = 256,
  parameter int unsigned VLEN    = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  decode_issue_ctrl_if.slave io
);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned FIFO_W = ENTRY_W + 1;

  decode_ctrl_state_e state_q, state_d;

  logic               vld_p0;
  logic [INSTR_W-1:0] instr_p0;
  logic [VLEN-1:0]    pc_p0;
  logic               comp_p0;

  logic [CNT_W-1:0]   count;
  logic [FIFO_W-1:0]  head;
  logic               issue_valid, issue_hs, dreg_move, push;
  logic               fetch_ready, fetch_hs;

  assign issue_valid = (count != '0);
  assign issue_hs    = issue_valid && io.issue_ready_i;
  // The register drains when there is room, including room made by this cycle's pop.
  assign dreg_move   = vld_p0 && ((count < CNT_W'(DEPTH)) || issue_hs);
  assign push        = dreg_move && !io.flush_i;
  // Refill the register only when it is empty or draining a non-serializing op.
  assign fetch_ready = !rst_i && (state_q == RUN) && !io.flush_i &&
                       (!vld_p0 || (dreg_move && !io.dec_serial_i));
  assign fetch_hs    = io.fetch_valid_i && fetch_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // A serializing push beats a same-cycle commit; flush beats everything.
  always_comb begin
    state_d = state_q;
    if (io.flush_i)                           state_d = RUN;
    else if (push && io.dec_serial_i)         state_d = SERIAL;
    else if (state_q == SERIAL && io.commit_serial_i) state_d = RUN;
  end

  // ---- stage p0: decoder input register ----
  always_ff @(posedge clk_i) begin
    if (rst_i || io.flush_i) vld_p0 <= 1'b0;
    else if (fetch_hs)       vld_p0 <= 1'b1;
    else if (dreg_move)      vld_p0 <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_p0 <= '0;
      pc_p0    <= '0;
      comp_p0  <= 1'b0;
    end else if (fetch_hs) begin
      instr_p0 <= io.fetch_instr_i;
      pc_p0    <= io.fetch_pc_i;
      comp_p0  <= io.fetch_is_compressed_i;
    end
  end

  // ---- stage p1: decoded-entry FIFO toward issue ----
  decode_entry_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (io.flush_i),
    .push_i  (push),
    .pop_i   (issue_hs),
    .wdata_i ({io.dec_serial_i, io.dec_entry_i}),
    .rdata_o (head),
    .count_o (count)
  );

  assign io.fetch_ready_o       = fetch_ready;
  assign io.dec_valid_o         = vld_p0;
  assign io.dec_instr_o         = instr_p0;
  assign io.dec_pc_o            = pc_p0;
  assign io.dec_is_compressed_o = comp_p0;
  assign io.issue_valid_o       = issue_valid;
  assign io.issue_serial_o      = head[FIFO_W-1];
  assign io.issue_entry_o       = head[ENTRY_W-1:0];
  assign io.stall_o             = (state_q == SERIAL);
endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned ENTRY_W = 256;
  localparam int unsigned VLEN    = 64;
  localparam logic [31:0] ADD = 32'h00b50533;
  localparam logic [31:0] CSR = 32'h30002573;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   acc;
  int   n;

  decode_issue_ctrl_if #(.ENTRY_W(ENTRY_W), .VLEN(VLEN)) io ();

  decode_issue_ctrl #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .VLEN(VLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (io)
  );

  // Decoder model: entry carries {pad, pc, instr}; SYSTEM opcode serializes.
  assign io.dec_entry_i  = {160'd0, io.dec_pc_o, io.dec_instr_o};
  assign io.dec_serial_i = (io.dec_instr_o[6:0] == 7'h73);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic fv, input logic [63:0] pc, input logic [31:0] instr);
    io.fetch_valid_i = fv;
    io.fetch_pc_i    = pc;
    io.fetch_instr_i = instr;
  endtask

  function automatic logic [63:0] head_pc();
    return io.issue_entry_o[95:32];
  endfunction

  initial begin
    rst = 1'b1;
    io.flush_i = 1'b0;
    io.fetch_is_compressed_i = 1'b0;
    io.issue_ready_i = 1'b0;
    io.commit_serial_i = 1'b0;
    offer(1'b0, 64'd0, 32'd0);

    // reset state
    nxt(); #1;
    chk("rst_rdy",   io.fetch_ready_o, 1'b0);
    chk("rst_dvld",  io.dec_valid_o, 1'b0);
    chk("rst_ivld",  io.issue_valid_o, 1'b0);
    chk("rst_stall", io.stall_o, 1'b0);
    chk("rst_entry", {63'd0, |io.issue_entry_o}, 64'd0);
    chk("rst_dpc",   io.dec_pc_o, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy_after", io.fetch_ready_o, 1'b1);

    // streaming
    io.issue_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      nxt();
      if (k < 8) offer(1'b1, 64'h8000_0000 + 64'(4 * k), ADD);
      else       offer(1'b0, 64'd0, ADD);
      #1;
      if (k < 8) chk("stream_rdy", io.fetch_ready_o, 1'b1);
      chk("stream_ivld", io.issue_valid_o, (k >= 2 && k < 10));
      if (k >= 2 && k < 10) chk("stream_pc", head_pc(), 64'h8000_0000 + 64'(4 * (k - 2)));
    end

    // backpressure
    io.issue_ready_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      offer(acc < 4, 64'h8000_0100 + 64'(4 * acc), ADD);
      #1;
      if (io.fetch_valid_i && io.fetch_ready_o) acc++;
    end
    chk("bp_acc",  64'(acc), 64'd3);
    chk("bp_rdy0", io.fetch_ready_o, 1'b0);
    chk("bp_ivld", io.issue_valid_o, 1'b1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      nxt();
      offer(1'b0, 64'd0, ADD);
      io.issue_ready_i = 1'b1;
      #1;
      if (io.issue_valid_o) begin
        chk("bp_pc", head_pc(), 64'h8000_0100 + 64'(4 * n));
        n++;
      end
    end
    chk("bp_cnt", 64'(n), 64'd3);

    // serializing
    nxt(); offer(1'b1, 64'h8000_0200, CSR); #1;
    chk("ser_rdy0", io.fetch_ready_o, 1'b1);
    nxt(); offer(1'b1, 64'h8000_0204, ADD); #1;
    chk("ser_hold", io.fetch_ready_o, 1'b0);
    chk("ser_dvld", io.dec_valid_o, 1'b1);
    nxt(); #1;
    chk("ser_stall", io.stall_o, 1'b1);
    chk("ser_rdy",   io.fetch_ready_o, 1'b0);
    chk("ser_ivld",  io.issue_valid_o, 1'b1);
    chk("ser_pc",    head_pc(), 64'h8000_0200);
    chk("ser_iser",  io.issue_serial_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      nxt(); #1;
      chk("ser_wait_stall", io.stall_o, 1'b1);
      chk("ser_wait_rdy",   io.fetch_ready_o, 1'b0);
      chk("ser_wait_ivld",  io.issue_valid_o, 1'b0);
    end
    nxt(); io.commit_serial_i = 1'b1; #1;
    chk("ser_cmt_stall", io.stall_o, 1'b1);
    nxt(); io.commit_serial_i = 1'b0; #1;
    chk("ser_rel_stall", io.stall_o, 1'b0);
    chk("ser_rel_rdy",   io.fetch_ready_o, 1'b1);
    nxt(); offer(1'b0, 64'd0, ADD); #1;
    chk("ser_add_dvld", io.dec_valid_o, 1'b1);
    chk("ser_add_dpc",  io.dec_pc_o, 64'h8000_0204);
    nxt(); #1;
    chk("ser_add_ivld", io.issue_valid_o, 1'b1);
    chk("ser_add_pc",   head_pc(), 64'h8000_0204);
    chk("ser_add_iser", io.issue_serial_o, 1'b0);

    // serializing push and commit in the same cycle: push wins
    nxt(); offer(1'b1, 64'h8000_0400, CSR); #1;
    nxt(); offer(1'b0, 64'd0, ADD); io.commit_serial_i = 1'b1; #1;
    nxt(); io.commit_serial_i = 1'b0; #1;
    chk("pw_stall", io.stall_o, 1'b1);
    chk("pw_rdy",   io.fetch_ready_o, 1'b0);
    nxt(); io.commit_serial_i = 1'b1; #1;
    nxt(); io.commit_serial_i = 1'b0; #1;
    chk("pw_rel_stall", io.stall_o, 1'b0);

    // flush together with commit while in SERIAL
    io.issue_ready_i = 1'b0;
    nxt(); offer(1'b1, 64'h8000_0500, CSR); #1;
    nxt(); offer(1'b0, 64'd0, ADD); #1;
    nxt(); #1;
    chk("fc_stall", io.stall_o, 1'b1);
    chk("fc_ivld",  io.issue_valid_o, 1'b1);
    nxt(); io.flush_i = 1'b1; io.commit_serial_i = 1'b1; #1;
    chk("fc_rdy_flush", io.fetch_ready_o, 1'b0);
    nxt(); io.flush_i = 1'b0; io.commit_serial_i = 1'b0; #1;
    chk("fc_after_stall", io.stall_o, 1'b0);
    chk("fc_after_ivld",  io.issue_valid_o, 1'b0);
    chk("fc_after_dvld",  io.dec_valid_o, 1'b0);
    chk("fc_after_rdy",   io.fetch_ready_o, 1'b1);
    nxt(); io.commit_serial_i = 1'b1; #1;
    nxt(); io.commit_serial_i = 1'b0; #1;
    chk("fc_stray_stall", io.stall_o, 1'b0);
    chk("fc_stray_rdy",   io.fetch_ready_o, 1'b1);

    // flush mid-stream with FIFO full and dreg valid
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      nxt();
      offer(acc < 3, 64'h8000_0300 + 64'(4 * acc), ADD);
      #1;
      if (io.fetch_valid_i && io.fetch_ready_o) acc++;
    end
    chk("fl_dvld_pre", io.dec_valid_o, 1'b1);
    chk("fl_ivld_pre", io.issue_valid_o, 1'b1);
    nxt(); io.flush_i = 1'b1; offer(1'b1, 64'h8000_1000, ADD); #1;
    chk("fl_rdy_flush", io.fetch_ready_o, 1'b0);
    nxt(); io.flush_i = 1'b0; io.issue_ready_i = 1'b1; #1;
    chk("fl_ivld", io.issue_valid_o, 1'b0);
    chk("fl_dvld", io.dec_valid_o, 1'b0);
    chk("fl_stall", io.stall_o, 1'b0);
    chk("fl_rdy",  io.fetch_ready_o, 1'b1);
    nxt(); offer(1'b0, 64'd0, ADD); #1;
    chk("fl_new_ivld0", io.issue_valid_o, 1'b0);
    chk("fl_new_dpc",   io.dec_pc_o, 64'h8000_1000);
    nxt(); #1;
    chk("fl_new_ivld", io.issue_valid_o, 1'b1);
    chk("fl_new_pc",   head_pc(), 64'h8000_1000);
    nxt(); #1;
    chk("fl_new_done", io.issue_valid_o, 1'b0);

    // reset mid-operation with two entries buffered
    io.issue_ready_i = 1'b0;
    nxt(); offer(1'b1, 64'h8000_0600, ADD); #1;
    nxt(); offer(1'b1, 64'h8000_0604, ADD); #1;
    nxt(); offer(1'b0, 64'd0, ADD); #1;
    chk("rm_ivld_pre", io.issue_valid_o, 1'b1);
    nxt(); rst = 1'b1; #1;
    chk("rm_ivld_buf", io.issue_valid_o, 1'b1);
    chk("rm_rdy_rst",  io.fetch_ready_o, 1'b0);
    nxt(); rst = 1'b0; io.issue_ready_i = 1'b1; #1;
    chk("rm_dvld",   io.dec_valid_o, 1'b0);
    chk("rm_ivld",   io.issue_valid_o, 1'b0);
    chk("rm_stall",  io.stall_o, 1'b0);
    chk("rm_entry",  {63'd0, |io.issue_entry_o}, 64'd0);
    chk("rm_iser",   io.issue_serial_o, 1'b0);
    chk("rm_dpc",    io.dec_pc_o, 64'd0);
    chk("rm_dinstr", {32'd0, io.dec_instr_o}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      chk("rm_no_issue", io.issue_valid_o, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
